// File: rtl/bus_memory_responder.sv
// Data-bus responder: word-organised RAM plus a 16-byte MMIO window (LED, cycle counter, status).
// Read data is registered, so it follows the address by one cycle; stores commit at the same posedge.
module bus_memory_responder #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wr_data,
    input  logic [2:0]  bus_write_length,
    input  logic        bus_wr_enable,
    output logic [31:0] bus_read_data,
    output logic        bus_error,
    output logic [7:0]  led
);
    // Bus handshake: no valid/ready pair. Every cycle is an access; the responder is always
    // ready, a write is taken when bus_wr_enable=1 at posedge, and read data is valid one cycle later.
    localparam int IW = $clog2(RAM_WORDS);
    localparam int AW = IW + 2;

    localparam logic [1:0] REG_LED    = 2'd0;
    localparam logic [1:0] REG_CYCLE  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] cycle_count;

    logic          ram_hit;
    logic          mmio_hit;
    logic [IW-1:0] word_idx;
    logic [1:0]    reg_sel;
    logic          len_ok;
    logic          misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data;
    logic          wr_fault;
    logic          wr_ok;
    logic [31:0]   rd_word;

    assign ram_hit  = (bus_address[31:AW] == RAM_BASE[31:AW]);
    assign mmio_hit = (bus_address[31:4] == MMIO_BASE[31:4]);
    assign word_idx = bus_address[2 +: IW];
    assign reg_sel  = bus_address[3:2];

    // Store data is replicated across lanes so each byte enable picks its own slice.
    always_comb begin
        len_ok     = 1'b1;
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        lane_data  = 32'h0;
        case (bus_write_length)
            3'b000: begin
                byte_en   = 4'b0001 << bus_address[1:0];
                lane_data = {4{bus_wr_data[7:0]}};
            end
            3'b001: begin
                byte_en    = bus_address[1] ? 4'b1100 : 4'b0011;
                misaligned = bus_address[0];
                lane_data  = {2{bus_wr_data[15:0]}};
            end
            3'b010: begin
                byte_en    = 4'b1111;
                misaligned = |bus_address[1:0];
                lane_data  = bus_wr_data;
            end
            default: len_ok = 1'b0;
        endcase
    end

    assign wr_fault = bus_wr_enable & (~len_ok | misaligned | ~(ram_hit | mmio_hit));
    assign wr_ok    = bus_wr_enable & ~wr_fault;

    always_comb begin
        rd_word = 32'h0;
        if (ram_hit) begin
            rd_word = mem[word_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_LED:    rd_word = {24'h0, led};
                REG_CYCLE:  rd_word = cycle_count;
                REG_STATUS: rd_word = {31'h0, bus_error};
                default:    rd_word = 32'h0;
            endcase
        end
    end

    // RAM is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_read_data <= 32'h0;
            bus_error     <= 1'b0;
            led           <= 8'h0;
            cycle_count   <= 32'h0;
        end else begin
            bus_read_data <= rd_word;
            cycle_count   <= cycle_count + 32'd1;
            if (wr_ok && mmio_hit && reg_sel == REG_LED && byte_en[0]) begin
                led <= lane_data[7:0];
            end
            if (wr_fault) begin
                bus_error <= 1'b1;
            end else if (wr_ok && mmio_hit && reg_sel == REG_STATUS && byte_en[0] && lane_data[0]) begin
                bus_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: RAM stores/loads, sub-word lanes, error paths,
// MMIO LED / cycle counter / status, read-during-write ordering and mid-run reset.
module tb_bus_memory_responder;
    localparam logic [31:0] RAM_BASE  = 32'h0001_0000;
    localparam logic [31:0] MMIO_BASE = 32'h0002_0000;

    logic        clk;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_wr_data;
    logic [2:0]  bus_write_length;
    logic        bus_wr_enable;
    logic [31:0] bus_read_data;
    logic        bus_error;
    logic [7:0]  led;

    int checks_done;
    int error_count;

    logic [31:0] rd;
    logic [31:0] c0;
    logic [31:0] c1;

    bus_memory_responder #(
        .RAM_WORDS(1024),
        .RAM_BASE (RAM_BASE),
        .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus_address     (bus_address),
        .bus_wr_data     (bus_wr_data),
        .bus_write_length(bus_write_length),
        .bus_wr_enable   (bus_wr_enable),
        .bus_read_data   (bus_read_data),
        .bus_error       (bus_error),
        .led             (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_done++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] len);
        bus_address      = addr;
        bus_wr_data      = data;
        bus_write_length = len;
        bus_wr_enable    = 1'b1;
        @(posedge clk);
        #1;
        bus_wr_enable = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        bus_address   = addr;
        bus_wr_enable = 1'b0;
        @(posedge clk);
        #1;
        data = bus_read_data;
    endtask

    initial begin
        checks_done      = 0;
        error_count      = 0;
        reset            = 1'b1;
        bus_address      = MMIO_BASE + 32'h4;
        bus_wr_data      = 32'h0;
        bus_write_length = 3'b010;
        bus_wr_enable    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", bus_read_data, 32'h0);
        check("reset_error", {31'h0, bus_error}, 32'h0);
        check("reset_led", {24'h0, led}, 32'h0);
        reset = 1'b0;
        do_read(MMIO_BASE + 32'h4, rd);
        check("cycle_after_reset", rd, 32'h0);

        do_write(RAM_BASE + 32'h10, 32'hDEADBEEF, 3'b010);
        do_read(RAM_BASE + 32'h10, rd);
        check("word_rw", rd, 32'hDEADBEEF);
        check("word_rw_noerr", {31'h0, bus_error}, 32'h0);

        do_write(RAM_BASE + 32'h20, 32'h11223344, 3'b010);
        do_write(RAM_BASE + 32'h21, 32'hFFFF_FFAA, 3'b000);
        do_write(RAM_BASE + 32'h22, 32'hFFFF_5566, 3'b001);
        do_read(RAM_BASE + 32'h20, rd);
        check("byte_half_merge", rd, 32'h5566AA44);

        do_write(RAM_BASE + 32'h22, 32'hCAFEF00D, 3'b010);
        check("misaligned_word_err", {31'h0, bus_error}, 32'h1);
        do_read(MMIO_BASE + 32'h8, rd);
        check("status_read_set", rd, 32'h1);
        do_read(RAM_BASE + 32'h20, rd);
        check("misaligned_no_write", rd, 32'h5566AA44);
        do_write(MMIO_BASE + 32'h8, 32'h1, 3'b010);
        check("status_clear", {31'h0, bus_error}, 32'h0);
        do_read(MMIO_BASE + 32'h8, rd);
        check("status_read_clear", rd, 32'h0);

        do_write(RAM_BASE + 32'h11, 32'h1234, 3'b001);
        check("misaligned_half_err", {31'h0, bus_error}, 32'h1);
        do_write(MMIO_BASE + 32'h8, 32'h1, 3'b000);
        check("status_clear_byte", {31'h0, bus_error}, 32'h0);

        do_write(RAM_BASE + 32'h30, 32'h0, 3'b010);
        do_write(RAM_BASE + 32'h30, 32'h1, 3'b010);
        check("collision_old", bus_read_data, 32'h0);
        do_read(RAM_BASE + 32'h30, rd);
        check("collision_new", rd, 32'h1);

        do_write(MMIO_BASE + 32'h0, 32'h0000_005A, 3'b000);
        check("led_write", {24'h0, led}, 32'h5A);
        do_write(MMIO_BASE + 32'h1, 32'h0000_0033, 3'b000);
        check("led_lane1_ignored", {24'h0, led}, 32'h5A);
        do_read(MMIO_BASE + 32'h0, rd);
        check("led_read", rd, 32'h5A);
        do_write(MMIO_BASE + 32'h4, 32'h0, 3'b010);
        check("cycle_write_noerr", {31'h0, bus_error}, 32'h0);
        do_read(MMIO_BASE + 32'h4, c0);
        repeat (6) do_read(RAM_BASE, rd);
        do_read(MMIO_BASE + 32'h4, c1);
        check("cycle_delta", c1 - c0, 32'd7);
        do_read(MMIO_BASE + 32'hC, rd);
        check("reserved_read", rd, 32'h0);

        reset            = 1'b1;
        bus_address      = RAM_BASE + 32'h10;
        bus_wr_data      = 32'h0;
        bus_write_length = 3'b010;
        bus_wr_enable    = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_led", {24'h0, led}, 32'h0);
        check("midreset_rdata", bus_read_data, 32'h0);
        bus_wr_enable = 1'b0;
        bus_address   = MMIO_BASE + 32'h4;
        reset         = 1'b0;
        do_read(MMIO_BASE + 32'h4, rd);
        check("cycle_restart", rd, 32'h0);
        do_read(RAM_BASE + 32'h10, rd);
        check("ram_kept_over_reset", rd, 32'hDEADBEEF);

        do_write(MMIO_BASE + 32'h0, 32'h0000_00C3, 3'b010);
        do_write(32'h0003_0000, 32'h0000_0011, 3'b010);
        check("unmapped_write_err", {31'h0, bus_error}, 32'h1);
        check("unmapped_led_kept", {24'h0, led}, 32'hC3);
        do_read(32'h0003_0000, rd);
        check("unmapped_read_zero", rd, 32'h0);
        do_write(MMIO_BASE + 32'h8, 32'h1, 3'b010);
        do_read(32'h0003_0000, rd);
        check("unmapped_read_noerr", {31'h0, bus_error}, 32'h0);
        do_write(RAM_BASE + 32'h10, 32'h0, 3'b011);
        check("bad_len_err", {31'h0, bus_error}, 32'h1);
        do_read(RAM_BASE + 32'h10, rd);
        check("bad_len_no_write", rd, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks_done, error_count);
        $finish;
    end
endmodule
